// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
//
// A single fulladd cell is sequenced across a WIDTH-bit operand pair,
// one bit per clock, LSB first. It is the small, slow counterpart of a
// parallel ripple-carry adder. The host uses a start/done handshake.
//
// Parameters:
//   WIDTH  operand and sum width in bits (legal range 2..32, default 8)
//
// Ports:
//   clk    in   system clock, all state changes on its rising edge
//   reset  in   synchronous, active-high reset
//   start  in   request an addition, sampled only while idle
//   a, b   in   operands, captured on the accepted start edge
//   cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, sum/cout valid from this cycle on
//   sum    out  registered result, held until the next result
//   cout   out  registered carry-out of the MSB, held with sum
//   ovf    out  (only with SERIAL_ADD_OVF_EN defined) registered
//               two's-complement overflow flag, held with sum
//
// Configuration macro:
//   SERIAL_ADD_OVF_EN  adds the ovf output and its capture logic.

// One-bit full adder cell from the gate library.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the parity of the three inputs; carry is their majority.
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] s_next;

    // The only adder in the design: it always looks at the current LSBs
    // of the operand shift registers plus the running carry.
    fulladd u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Each new sum bit enters at the MSB end, so after WIDTH shifts the
    // first (LSB) result bit has travelled down to bit 0.
    assign s_next = {fa_sum, s_sh[WIDTH-1:1]};

    // Controller and datapath in one block. busy and done are registered
    // alongside the state so neither has a combinational path from start.
    // The result registers are written only when the last bit is summed,
    // so a run that is cut short by reset never exposes a partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    s_sh <= s_next;
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    c    <= fa_cout;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum   <= s_next;
                        cout  <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // c is the carry into the MSB at this point.
                        ovf   <= c ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
